// File: rtl/order_if.sv
// ----------------------------------------------------------------------------
// order_if
// Purpose : byte-stream link from the order transmitter to the exchange side.
//           One byte moves on every cycle where order_valid and order_ready
//           are both high; order_last marks the final byte of a frame.
// Signals :
//   order_data  [7:0]  frame byte              (master -> slave)
//   order_valid        order_data is valid     (master -> slave)
//   order_last         final byte of a frame   (master -> slave)
//   order_ready        sink accepts the byte   (slave  -> master)
// Modports: master (transmitter), slave (exchange link / testbench sink)
// ----------------------------------------------------------------------------
interface order_if;
    logic [7:0] order_data;
    logic       order_valid;
    logic       order_last;
    logic       order_ready;

    modport master (
        output order_data,
        output order_valid,
        output order_last,
        input  order_ready
    );

    modport slave (
        input  order_data,
        input  order_valid,
        input  order_last,
        output order_ready
    );
endinterface

// File: rtl/order_tx.sv
// ----------------------------------------------------------------------------
// order_tx
// Purpose : accepts buy/sell decisions, enforces a net-position limit and a
//           post-order cooldown, and serialises each accepted decision into a
//           5-byte frame (A5, side, qty, price, checksum) on a valid/ready
//           byte stream. Net position changes only when a frame completes.
// Parameters:
//   MAX_POS   absolute net-position limit (1..127)
//   QTY       quantity per order (1..MAX_POS)
//   COOLDOWN  idle cycles after a completed frame (0 = none)
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   buy_signal      request a buy this cycle (level)
//   sell_signal     request a sell this cycle (level)
//   price [7:0]     price latched with an accepted signal
//   ord             order byte stream (master side of order_if)
//   position [7:0]  signed net position
//   busy            high while sending a frame or cooling down
//   drop_count[7:0] rejected-signal cycles, saturating at 255
// ----------------------------------------------------------------------------
module order_tx #(
    parameter logic [7:0] MAX_POS  = 8'd4,
    parameter logic [7:0] QTY      = 8'd1,
    parameter logic [7:0] COOLDOWN = 8'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        buy_signal,
    input  logic        sell_signal,
    input  logic [7:0]  price,
    order_if.master     ord,
    output logic [7:0]  position,
    output logic        busy,
    output logic [7:0]  drop_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        COOL = 2'd2
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] BUY_BYTE  = 8'h42;
    localparam logic [7:0] SELL_BYTE = 8'h53;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       side_buy_q, side_buy_d;
    logic [7:0] price_q, price_d;
    logic [7:0] pos_q, pos_d;
    logic [7:0] drop_q, drop_d;
    logic [7:0] cool_q, cool_d;

    logic        reject;
    logic        beat;
    logic        buy_ok;
    logic        sell_ok;
    logic [7:0]  side_byte;
    logic [7:0]  frame_byte;
    logic signed [9:0] pos_ext;
    logic signed [9:0] qty_ext;
    logic signed [9:0] max_ext;

    // Position limit checks are done two bits wider than the position so
    // that pos +/- QTY can be compared against +/-MAX_POS without wrapping.
    always_comb begin
        pos_ext = $signed({{2{pos_q[7]}}, pos_q});
        qty_ext = $signed({2'b00, QTY});
        max_ext = $signed({2'b00, MAX_POS});
        buy_ok  = (pos_ext + qty_ext) <= max_ext;
        sell_ok = (pos_ext - qty_ext) >= -max_ext;
    end

    // Frame byte selected by the current byte index. The checksum is rebuilt
    // from the latched side and price so nothing extra needs storing.
    always_comb begin
        side_byte  = side_buy_q ? BUY_BYTE : SELL_BYTE;
        frame_byte = 8'h00;
        case (idx_q)
            3'd0:    frame_byte = SYNC_BYTE;
            3'd1:    frame_byte = side_byte;
            3'd2:    frame_byte = QTY;
            3'd3:    frame_byte = price_q;
            3'd4:    frame_byte = side_byte ^ QTY ^ price_q;
            default: frame_byte = 8'h00;
        endcase
    end

    // A byte leaves only when we present it and the sink takes it.
    assign beat = (state_q == SEND) && ord.order_ready;

    // Next-state and datapath logic. IDLE decides accept/reject, SEND walks
    // the five bytes under back-pressure and commits the position on the
    // last one, COOL counts down before new signals are honoured. Any signal
    // seen outside IDLE, and any refused signal in IDLE, counts as a drop.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        side_buy_d = side_buy_q;
        price_d    = price_q;
        pos_d      = pos_q;
        cool_d     = cool_q;
        reject     = 1'b0;

        case (state_q)
            IDLE: begin
                if (buy_signal && sell_signal) begin
                    reject = 1'b1;
                end else if (buy_signal) begin
                    if (buy_ok) begin
                        side_buy_d = 1'b1;
                        price_d    = price;
                        idx_d      = 3'd0;
                        state_d    = SEND;
                    end else begin
                        reject = 1'b1;
                    end
                end else if (sell_signal) begin
                    if (sell_ok) begin
                        side_buy_d = 1'b0;
                        price_d    = price;
                        idx_d      = 3'd0;
                        state_d    = SEND;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end

            SEND: begin
                reject = buy_signal | sell_signal;
                if (beat) begin
                    if (idx_q == 3'd4) begin
                        pos_d  = side_buy_q ? (pos_q + QTY) : (pos_q - QTY);
                        idx_d  = 3'd0;
                        cool_d = COOLDOWN;
                        if (COOLDOWN == 8'd0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = COOL;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            COOL: begin
                reject = buy_signal | sell_signal;
                if (cool_q <= 8'd1) begin
                    cool_d  = 8'd0;
                    state_d = IDLE;
                end else begin
                    cool_d = cool_q - 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        drop_d = drop_q;
        if (reject && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // State register. Reset aborts any frame in flight without touching the
    // position beyond clearing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            side_buy_q <= 1'b0;
            price_q    <= 8'h00;
            pos_q      <= 8'h00;
            drop_q     <= 8'h00;
            cool_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            side_buy_q <= side_buy_d;
            price_q    <= price_d;
            pos_q      <= pos_d;
            drop_q     <= drop_d;
            cool_q     <= cool_d;
        end
    end

    // Outputs come straight from registered state, so data/last stay stable
    // while the sink stalls and valid cannot drop mid-frame.
    always_comb begin
        ord.order_valid = (state_q == SEND);
        ord.order_last  = (state_q == SEND) && (idx_q == 3'd4);
        ord.order_data  = (state_q == SEND) ? frame_byte : 8'h00;
        position        = pos_q;
        busy            = (state_q != IDLE);
        drop_count      = drop_q;
    end

endmodule

// File: tb/tb_order_tx.sv
// ----------------------------------------------------------------------------
// tb_order_tx
// Purpose : self-checking bench for order_tx with default parameters
//           (MAX_POS=4, QTY=1, COOLDOWN=8). Directed scenarios plus a long
//           randomized run checked against a transaction-level model.
// ----------------------------------------------------------------------------
module tb_order_tx;

    localparam int MAX_POS  = 4;
    localparam int QTY      = 1;
    localparam int COOLDOWN = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       buy;
    logic       sell;
    logic [7:0] price;
    logic [7:0] position;
    logic       busy;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;

    order_if ord();

    order_tx #(
        .MAX_POS (8'(MAX_POS)),
        .QTY     (8'(QTY)),
        .COOLDOWN(8'(COOLDOWN))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .buy_signal (buy),
        .sell_signal(sell),
        .price      (price),
        .ord        (ord.master),
        .position   (position),
        .busy       (busy),
        .drop_count (drop_count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Reference model state: bytes still to send in the current frame,
    // remaining cooldown cycles, net position and drop count.
    logic [7:0] m_frame[$];
    int         m_cool;
    int         m_pos;
    int         m_drop;
    int         m_side;

    function automatic logic [7:0] side_code(input bit is_buy);
        return is_buy ? 8'h42 : 8'h53;
    endfunction

    // Advances the model across one rising edge with the given inputs.
    task automatic model_edge(input bit b, input bit s, input bit r, input logic [7:0] p);
        bit dropped;
        logic [7:0] sb;
        dropped = 1'b0;
        if (m_frame.size() > 0) begin
            dropped = b | s;
            if (r) begin
                void'(m_frame.pop_front());
                if (m_frame.size() == 0) begin
                    m_pos  = m_pos + m_side * QTY;
                    m_cool = COOLDOWN;
                end
            end
        end else if (m_cool > 0) begin
            dropped = b | s;
            m_cool  = m_cool - 1;
        end else if (b && s) begin
            dropped = 1'b1;
        end else if (b || s) begin
            if ((b && (m_pos + QTY <= MAX_POS)) || (s && (m_pos - QTY >= -MAX_POS))) begin
                m_side = b ? 1 : -1;
                sb = side_code(b);
                m_frame = '{8'hA5, sb, 8'(QTY), p, sb ^ 8'(QTY) ^ p};
            end else begin
                dropped = 1'b1;
            end
        end
        if (dropped && m_drop < 255) m_drop = m_drop + 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        buy = 1'b0;
        sell = 1'b0;
        price = 8'h00;
        ord.order_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ord.order_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", ord.order_valid); end
        checks++; if (ord.order_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got %b expected 0", ord.order_last); end
        checks++; if (ord.order_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h expected 00", ord.order_data); end
        checks++; if (position !== 8'h00) begin errors++; $display("[TB] FAIL reset_position got %h expected 00", position); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        checks++; if (drop_count !== 8'h00) begin errors++; $display("[TB] FAIL reset_drop got %0d expected 0", drop_count); end
    endtask

    task automatic test_buy_frame();
        logic [7:0] exp_bytes[5];
        int busy_cycles;
        exp_bytes = '{8'hA5, 8'h42, 8'h01, 8'h64, 8'h27};
        do_reset();
        ord.order_ready = 1'b1;
        buy = 1'b1;
        price = 8'h64;
        @(negedge clk);
        buy = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL buy_busy_t1 got %b expected 1", busy); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (ord.order_valid !== 1'b1) begin errors++; $display("[TB] FAIL buy_valid[%0d] got %b expected 1", i, ord.order_valid); end
            checks++; if (ord.order_data !== exp_bytes[i]) begin errors++; $display("[TB] FAIL buy_byte[%0d] got %h expected %h", i, ord.order_data, exp_bytes[i]); end
            checks++; if (ord.order_last !== (i == 4)) begin errors++; $display("[TB] FAIL buy_last[%0d] got %b expected %b", i, ord.order_last, (i == 4)); end
            @(negedge clk);
        end
        checks++; if (ord.order_valid !== 1'b0) begin errors++; $display("[TB] FAIL buy_valid_after got %b expected 0", ord.order_valid); end
        checks++; if (position !== 8'h01) begin errors++; $display("[TB] FAIL buy_position got %h expected 01", position); end
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 50) begin
            busy_cycles++;
            @(negedge clk);
        end
        checks++; if (busy_cycles !== COOLDOWN) begin errors++; $display("[TB] FAIL buy_cool_cycles got %0d expected %0d", busy_cycles, COOLDOWN); end
    endtask

    task automatic test_sell_backpressure();
        logic [7:0] exp_bytes[5];
        int idx;
        int n;
        bit r;
        exp_bytes = '{8'hA5, 8'h53, 8'h01, 8'h80, 8'hD2};
        do_reset();
        ord.order_ready = 1'b1;
        sell = 1'b1;
        price = 8'h80;
        @(negedge clk);
        sell = 1'b0;
        idx = 0;
        n = 0;
        r = 1'b1;
        while (idx < 5 && n < 40) begin
            checks++; if (ord.order_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d] got %b expected 1", idx, ord.order_valid); end
            checks++; if (ord.order_data !== exp_bytes[idx]) begin errors++; $display("[TB] FAIL bp_byte[%0d] got %h expected %h", idx, ord.order_data, exp_bytes[idx]); end
            checks++; if (ord.order_last !== (idx == 4)) begin errors++; $display("[TB] FAIL bp_last[%0d] got %b expected %b", idx, ord.order_last, (idx == 4)); end
            ord.order_ready = r;
            @(negedge clk);
            if (r) idx++;
            r = ~r;
            n++;
        end
        checks++; if (idx != 5) begin errors++; $display("[TB] FAIL bp_timeout got %0d bytes expected 5", idx); end
        checks++; if (ord.order_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_after got %b expected 0", ord.order_valid); end
        checks++; if (position !== 8'hFF) begin errors++; $display("[TB] FAIL bp_position got %h expected ff", position); end
    endtask

    task automatic test_position_limit();
        int frames;
        int n;
        do_reset();
        ord.order_ready = 1'b1;
        price = 8'h10;
        frames = 0;
        for (int i = 0; i < 100; i++) begin
            buy = 1'b1;
            if (ord.order_valid && ord.order_last) frames++;
            @(negedge clk);
        end
        buy = 1'b0;
        checks++; if (frames != 4) begin errors++; $display("[TB] FAIL limit_frames got %0d expected 4", frames); end
        checks++; if (position !== 8'h04) begin errors++; $display("[TB] FAIL limit_position got %h expected 04", position); end
        checks++; if (drop_count !== 8'd96) begin errors++; $display("[TB] FAIL limit_drops got %0d expected 96", drop_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL limit_idle got %b expected 0", busy); end
        sell = 1'b1;
        @(negedge clk);
        sell = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++; if (position !== 8'h03) begin errors++; $display("[TB] FAIL limit_sell_position got %h expected 03", position); end
    endtask

    task automatic test_conflict();
        do_reset();
        ord.order_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            buy = 1'b1;
            sell = 1'b1;
            @(negedge clk);
            checks++; if (ord.order_valid !== 1'b0) begin errors++; $display("[TB] FAIL conflict_valid[%0d] got %b expected 0", i, ord.order_valid); end
        end
        buy = 1'b0;
        sell = 1'b0;
        @(negedge clk);
        checks++; if (drop_count !== 8'd3) begin errors++; $display("[TB] FAIL conflict_drops got %0d expected 3", drop_count); end
        checks++; if (position !== 8'h00) begin errors++; $display("[TB] FAIL conflict_position got %h expected 00", position); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL conflict_busy got %b expected 0", busy); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] p2;
        logic [7:0] exp_bytes[5];
        do_reset();
        ord.order_ready = 1'b1;
        buy = 1'b1;
        price = 8'($urandom_range(0, 255));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        buy = 1'b0;
        @(negedge clk);
        checks++; if (ord.order_data !== price) begin errors++; $display("[TB] FAIL mid_byte3 got %h expected %h", ord.order_data, price); end
        checks++; if (drop_count !== 8'd2) begin errors++; $display("[TB] FAIL mid_drops got %0d expected 2", drop_count); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ord.order_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid got %b expected 0", ord.order_valid); end
        checks++; if (position !== 8'h00) begin errors++; $display("[TB] FAIL mid_position got %h expected 00", position); end
        checks++; if (drop_count !== 8'h00) begin errors++; $display("[TB] FAIL mid_drop got %0d expected 0", drop_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy got %b expected 0", busy); end
        p2 = 8'($urandom_range(0, 255));
        exp_bytes = '{8'hA5, 8'h42, 8'h01, p2, 8'h43 ^ p2};
        buy = 1'b1;
        price = p2;
        @(negedge clk);
        buy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (ord.order_data !== exp_bytes[i] || ord.order_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_fresh_byte[%0d] got %h/%b expected %h/1", i, ord.order_data, ord.order_valid, exp_bytes[i]); end
            @(negedge clk);
        end
        checks++; if (position !== 8'h01) begin errors++; $display("[TB] FAIL mid_fresh_position got %h expected 01", position); end
    endtask

    task automatic test_drop_saturation();
        do_reset();
        buy = 1'b1;
        sell = 1'b1;
        for (int i = 0; i < 255; i++) @(negedge clk);
        checks++; if (drop_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_at_255 got %0d expected 255", drop_count); end
        for (int i = 0; i < 45; i++) @(negedge clk);
        buy = 1'b0;
        sell = 1'b0;
        checks++; if (drop_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_after_300 got %0d expected 255", drop_count); end
    endtask

    task automatic test_random();
        bit b, s, r;
        logic [7:0] p;
        bit exp_valid;
        bit exp_busy;
        do_reset();
        m_frame.delete();
        m_cool = 0;
        m_pos = 0;
        m_drop = 0;
        m_side = 1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            exp_valid = (m_frame.size() > 0);
            exp_busy  = exp_valid || (m_cool > 0);
            checks++; if (ord.order_valid !== exp_valid) begin errors++; $display("[TB] FAIL rnd_valid cyc %0d got %b expected %b", cyc, ord.order_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (ord.order_data !== m_frame[0]) begin errors++; $display("[TB] FAIL rnd_data cyc %0d got %h expected %h", cyc, ord.order_data, m_frame[0]); end
                checks++; if (ord.order_last !== (m_frame.size() == 1)) begin errors++; $display("[TB] FAIL rnd_last cyc %0d got %b expected %b", cyc, ord.order_last, (m_frame.size() == 1)); end
            end
            checks++; if (busy !== exp_busy) begin errors++; $display("[TB] FAIL rnd_busy cyc %0d got %b expected %b", cyc, busy, exp_busy); end
            checks++; if (position !== 8'(m_pos)) begin errors++; $display("[TB] FAIL rnd_position cyc %0d got %h expected %h", cyc, position, 8'(m_pos)); end
            checks++; if (drop_count !== 8'(m_drop)) begin errors++; $display("[TB] FAIL rnd_drop cyc %0d got %0d expected %0d", cyc, drop_count, m_drop); end
            b = ($urandom_range(0, 99) < 20);
            s = ($urandom_range(0, 99) < 20);
            r = ($urandom_range(0, 99) < 70);
            p = 8'($urandom_range(0, 255));
            buy = b;
            sell = s;
            ord.order_ready = r;
            price = p;
            model_edge(b, s, r, p);
            @(negedge clk);
        end
        buy = 1'b0;
        sell = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        buy = 1'b0;
        sell = 1'b0;
        price = 8'h00;
        ord.order_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_buy_frame();
        test_sell_backpressure();
        test_position_limit();
        test_conflict();
        test_reset_midframe();
        test_drop_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
